baseline_detector: RTL and testbench
====================================

Name: baseline_detector

Overview:
Consumer at the far end of the baseline interface. It latches the long-window baseline (value plus data_valid) and compares each incoming short-window feature sample against a scaled threshold. A small state machine requires N consecutive exceedances to raise an alarm, then holds off re-triggering for a refractory period. It sits after the baseline tracker and the feature extractor, and drives the seizure-alarm output.

Parameters:
FEAT_WIDTH, 25, width of the signed short-window feature input
BASE_WIDTH, 37, width of the unsigned baseline input
MULT_WIDTH, 4, width of the threshold multiplier port
CONSEC_CNT, 3, consecutive exceedances required to alarm (legal range 1..15)
REFRACT_LEN, 4, feature samples ignored after an alarm ends (legal range 1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
en  in  1  active-low enable; high freezes all state
feat_in  in  FEAT_WIDTH  signed feature sample
feat_valid  in  1  feat_in valid this cycle
base_in  in  BASE_WIDTH  unsigned baseline value
base_valid  in  1  base_in valid this cycle
thresh_mult  in  MULT_WIDTH  unsigned threshold multiplier
alarm  out  1  high while in ALARM
alarm_pulse  out  1  one-cycle pulse on ALARM entry
state_out  out  3  current FSM state encoding
event_count  out  8  saturating count of ALARM entries

Behaviour:
- Reset (rst low, no clock needed): alarm=0, alarm_pulse=0, state=WAIT_BASE(0), event_count=0, base_reg=0, exceed counter=0, refractory timer=0.
- en high: no state, counter, timer or register changes; alarm_pulse forced to 0; outputs otherwise hold.
- Threshold: thr = base_reg * thresh_mult, computed unsigned at BASE_WIDTH+MULT_WIDTH bits with no truncation.
- Exceed condition: feat_in >= 0 and the zero-extended feat_in > thr (strictly greater). Negative features never exceed.
- Baseline capture: base_valid=1 loads base_reg, effective the next cycle. A feat_valid in the same cycle compares against the old base_reg.
- Only feat_valid cycles advance the FSM, counters and timer. feat_valid=0 holds everything.
- FSM states: WAIT_BASE(0), MONITOR(1), PENDING(2), ALARM(3), REFRACT(4).
- WAIT_BASE: features are ignored. The first base_valid moves to MONITOR.
- MONITOR: on exceed, cnt=1. If CONSEC_CNT==1 go to ALARM; otherwise go to PENDING.
- PENDING:
  - on exceed, cnt+1; when cnt reaches CONSEC_CNT, go to ALARM;
  - on non-exceed, cnt=0 and go to MONITOR.
- ALARM: alarm=1.
  - Stays in ALARM while samples exceed.
  - A non-exceed sample goes to REFRACT, loads timer=REFRACT_LEN and clears cnt.
- REFRACT: alarm=0 and exceedances are ignored. Each feat_valid decrements the timer; when it reaches 0, go to MONITOR.
- ALARM entry effects:
  - alarm rises the cycle after the completing feat_valid;
  - alarm_pulse is high for exactly that one cycle;
  - event_count increments and saturates at 255.
- Latency: 1 cycle from the registering feat_valid to alarm/state update.

Optional Feature:
DETECT_FREEZE_BASE_EN
- Defined: base_valid is ignored while in PENDING, ALARM or REFRACT, so ictal activity cannot inflate the baseline. Updates resume in MONITOR and WAIT_BASE.
- Undefined: base_valid updates base_reg in every state.

Test Plan:
1. Reset, then feat_valid with feat_in=1000 and no baseline loaded -> state stays 0, alarm=0. Assert rst low mid-ALARM -> alarm=0, state=0, event_count=0 immediately.
2. thresh_mult=4, base=100 (thr=400); feat 401,401,401 -> alarm rises the cycle after the third sample, alarm_pulse high 1 cycle, event_count=1.
3. thr=400; feat 400 x5 -> no alarm (equality). Feat 401,401,0,401 -> counter resets, state ends in PENDING, no alarm. Feat -5 -> never exceeds.
4. In ALARM, feat 10 -> alarm falls, state=4. Then feat 401 x4 -> ignored, state=1 after the 4th. Next 401 -> state=2.
5. Same cycle: base_valid with base=200 and feat 500 -> exceed counted against 400. Next feat 500 -> compared against 800, not exceed, back to MONITOR. With DETECT_FREEZE_BASE_EN defined, a base update during ALARM is ignored.
6. en high for 10 cycles with feat_valid pulsing -> state, counters and timer unchanged. Force 256 ALARM entries -> event_count saturates at 255.

Source files
------------

// File: rtl/baseline_detector.sv
// Baseline-relative seizure detector: N consecutive exceedances of base*mult raise an alarm, followed by a refractory hold-off.
// Optional: `define DETECT_FREEZE_BASE_EN to ignore baseline updates while in PENDING/ALARM/REFRACT.
module baseline_detector #(
    parameter int unsigned FEAT_WIDTH  = 25,
    parameter int unsigned BASE_WIDTH  = 37,
    parameter int unsigned MULT_WIDTH  = 4,
    parameter int unsigned CONSEC_CNT  = 3,
    parameter int unsigned REFRACT_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [FEAT_WIDTH-1:0] feat_in,
    input  logic                         feat_valid,
    input  logic        [BASE_WIDTH-1:0] base_in,
    input  logic                         base_valid,
    input  logic        [MULT_WIDTH-1:0] thresh_mult,
    output logic                         alarm,
    output logic                         alarm_pulse,
    output logic        [2:0]            state_out,
    output logic        [7:0]            event_count
);

    typedef enum logic [2:0] {
        WAIT_BASE = 3'd0,
        MONITOR   = 3'd1,
        PENDING   = 3'd2,
        ALARM     = 3'd3,
        REFRACT   = 3'd4
    } state_t;

    localparam int unsigned THR_WIDTH = BASE_WIDTH + MULT_WIDTH;
    localparam int unsigned CMP_WIDTH = (FEAT_WIDTH > THR_WIDTH) ? FEAT_WIDTH : THR_WIDTH;

    state_t                r_state;
    logic [BASE_WIDTH-1:0] r_base;
    logic [3:0]            r_cnt;
    logic [7:0]            r_timer;

    logic [THR_WIDTH-1:0]  w_thr;
    logic [FEAT_WIDTH-1:0] w_feat_u;
    logic                  w_exceed;
    logic                  w_base_load;
    logic [3:0]            w_cnt_inc;
    logic                  w_enter_alarm;

    assign w_thr     = THR_WIDTH'(r_base) * THR_WIDTH'(thresh_mult);
    assign w_feat_u  = feat_in;
    // Sign bit gates the comparison so negative features never exceed.
    assign w_exceed  = !feat_in[FEAT_WIDTH-1] && (CMP_WIDTH'(w_feat_u) > CMP_WIDTH'(w_thr));
    assign w_cnt_inc = r_cnt + 4'd1;

`ifdef DETECT_FREEZE_BASE_EN
    assign w_base_load = base_valid && ((r_state == WAIT_BASE) || (r_state == MONITOR));
`else
    assign w_base_load = base_valid;
`endif

    assign w_enter_alarm = feat_valid && w_exceed &&
                           (((r_state == MONITOR) && (CONSEC_CNT == 1)) ||
                            ((r_state == PENDING) && (w_cnt_inc == 4'(CONSEC_CNT))));

    assign state_out = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WAIT_BASE;
            r_base      <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            alarm       <= 1'b0;
            alarm_pulse <= 1'b0;
            event_count <= '0;
        end else if (en) begin
            alarm_pulse <= 1'b0;
        end else begin
            alarm_pulse <= 1'b0;
            if (w_base_load)
                r_base <= base_in;

            case (r_state)
                WAIT_BASE: begin
                    if (base_valid)
                        r_state <= MONITOR;
                end
                MONITOR: begin
                    if (feat_valid && w_exceed) begin
                        r_cnt   <= 4'd1;
                        r_state <= PENDING;
                    end
                end
                PENDING: begin
                    if (feat_valid) begin
                        if (w_exceed) begin
                            r_cnt <= w_cnt_inc;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= MONITOR;
                        end
                    end
                end
                ALARM: begin
                    if (feat_valid && !w_exceed) begin
                        r_state <= REFRACT;
                        r_timer <= 8'(REFRACT_LEN);
                        r_cnt   <= '0;
                        alarm   <= 1'b0;
                    end
                end
                REFRACT: begin
                    if (feat_valid) begin
                        r_timer <= r_timer - 8'd1;
                        if (r_timer <= 8'd1)
                            r_state <= MONITOR;
                    end
                end
                default: r_state <= WAIT_BASE;
            endcase

            // Placed after the case so ALARM entry overrides the PENDING target from MONITOR.
            if (w_enter_alarm) begin
                r_state     <= ALARM;
                alarm       <= 1'b1;
                alarm_pulse <= 1'b1;
                if (event_count != 8'hFF)
                    event_count <= event_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_baseline_detector.sv
// Randomized + directed bench for baseline_detector against a streak/timer reference model.
module tb_baseline_detector;

    localparam int CONSEC  = 3;
    localparam int REFRACT = 4;
`ifdef DETECT_FREEZE_BASE_EN
    localparam bit FREEZE = 1'b1;
`else
    localparam bit FREEZE = 1'b0;
`endif
    localparam int S_WAIT = 0, S_MON = 1, S_PEND = 2, S_ALM = 3, S_REF = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [24:0] feat_in;
    logic               feat_valid;
    logic        [36:0] base_in;
    logic               base_valid;
    logic        [3:0]  thresh_mult;
    logic               alarm;
    logic               alarm_pulse;
    logic        [2:0]  state_out;
    logic        [7:0]  event_count;

    int n_checks = 0;
    int n_errors = 0;

    int     m_state, m_streak, m_timer, m_events;
    longint m_base;
    bit     m_alarm, m_pulse;

    baseline_detector #(
        .FEAT_WIDTH (25),
        .BASE_WIDTH (37),
        .MULT_WIDTH (4),
        .CONSEC_CNT (CONSEC),
        .REFRACT_LEN(REFRACT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .feat_in    (feat_in),
        .feat_valid (feat_valid),
        .base_in    (base_in),
        .base_valid (base_valid),
        .thresh_mult(thresh_mult),
        .alarm      (alarm),
        .alarm_pulse(alarm_pulse),
        .state_out  (state_out),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_WAIT; m_streak = 0; m_timer = 0; m_events = 0;
        m_base = 0; m_alarm = 0; m_pulse = 0;
    endtask

    task automatic raise_alarm();
        m_state = S_ALM;
        m_alarm = 1;
        m_pulse = 1;
        if (m_events < 255) m_events++;
    endtask

    // One clock edge of the reference: streak of exceeding samples, refractory countdown.
    task automatic model_step(input bit e, input bit fv, input longint f,
                              input bit bv, input longint b, input longint m);
        bit exc;
        int prev;
        m_pulse = 0;
        if (e) return;
        prev = m_state;
        exc  = (f >= 0) && (f > m_base * m);
        if (bv && (!FREEZE || prev == S_WAIT || prev == S_MON)) m_base = b;
        if (prev == S_WAIT) begin
            if (bv) m_state = S_MON;
        end else if (fv) begin
            if (prev == S_REF) begin
                m_timer--;
                if (m_timer == 0) m_state = S_MON;
            end else if (prev == S_ALM) begin
                if (!exc) begin
                    m_state = S_REF; m_timer = REFRACT; m_alarm = 0; m_streak = 0;
                end
            end else if (exc) begin
                m_streak++;
                if (m_streak >= CONSEC) raise_alarm();
                else m_state = S_PEND;
            end else begin
                m_streak = 0;
                m_state  = S_MON;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".state"}, state_out,   m_state);
        check_eq({tag, ".alarm"}, alarm,       m_alarm);
        check_eq({tag, ".pulse"}, alarm_pulse, m_pulse);
        check_eq({tag, ".evcnt"}, event_count, m_events);
    endtask

    task automatic step(input string tag, input bit e, input bit fv, input longint f,
                        input bit bv, input longint b, input longint m);
        en          = e;
        feat_valid  = fv;
        feat_in     = 25'(f);
        base_valid  = bv;
        base_in     = 37'(b);
        thresh_mult = 4'(m);
        @(posedge clk);
        model_step(e, fv, f, bv, b, m);
        #1;
        compare_all(tag);
    endtask

    task automatic feat(input string tag, input longint f);
        step(tag, 1'b0, 1'b1, f, 1'b0, 0, 4);
    endtask

    task automatic load_base(input longint b);
        step("base", 1'b0, 1'b0, 0, 1'b1, b, 4);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; feat_valid = 1'b0; feat_in = '0;
        base_valid = 1'b0; base_in = '0; thresh_mult = 4'd4;
        model_reset();
        #1;
        do_reset();

        // No baseline yet: features ignored.
        repeat (3) feat("nobase", 1000);
        load_base(100);

        // Three consecutive exceedances of thr=400.
        repeat (3) feat("t2", 401);
        check_eq("t2_alarm_up", alarm, 1);
        check_eq("t2_events", event_count, 1);
        feat("t2_hold", 401);

        // Leave alarm, refractory ignores exceedances.
        feat("t4_exit", 10);
        check_eq("t4_refract", state_out, 4);
        repeat (4) feat("t4_ref", 401);
        check_eq("t4_monitor", state_out, 1);
        feat("t4_pend", 401);
        check_eq("t4_pending", state_out, 2);

        // Equality, broken streak, negative features.
        feat("t3_clr", 0);
        repeat (5) feat("t3_eq", 400);
        feat("t3_a", 401); feat("t3_b", 401); feat("t3_c", 0); feat("t3_d", 401);
        check_eq("t3_pending", state_out, 2);
        check_eq("t3_noalarm", alarm, 0);
        repeat (3) feat("t3_neg", -5);

        // Same-cycle base update compares against the old baseline.
        step("t5_same", 1'b0, 1'b1, 500, 1'b1, 200, 4);
        check_eq("t5_pending", state_out, 2);
        feat("t5_new", 500);
        check_eq("t5_monitor", state_out, 1);

        // Base update during ALARM (ignored only with freeze).
        load_base(100);
        repeat (3) feat("t5_alm", 401);
        step("t5_bupd", 1'b0, 1'b0, 0, 1'b1, 1000, 4);
        feat("t5_after", 401);

        // Asynchronous reset in the middle of ALARM.
        do_reset();
        load_base(100);
        repeat (3) feat("t1_alm", 401);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("t1_async");
        #2;
        rst = 1'b1;

        // Enable high freezes everything.
        load_base(100);
        repeat (2) feat("t6_pre", 401);
        for (int i = 0; i < 10; i++)
            step("t6_frz", 1'b1, i[0], 401, 1'b1, 5, 4);
        feat("t6_post", 401);
        check_eq("t6_alarm", alarm, 1);
        feat("t6_exit", 10);
        for (int i = 0; i < 10; i++)
            step("t6_frz2", 1'b1, 1'b1, 0, 1'b0, 0, 4);
        repeat (4) feat("t6_ref", 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            longint b, m, thr, f;
            bit e, fv, bv;
            b   = longint'($urandom_range(0, 200));
            m   = longint'($urandom_range(0, 15));
            thr = m_base * m;
            f   = ($urandom_range(0, 7) == 0) ? -longint'($urandom_range(1, 100))
                                              : thr + longint'($urandom_range(0, 3)) - 1;
            e   = ($urandom_range(0, 9) == 0);
            fv  = ($urandom_range(0, 9) < 7);
            bv  = ($urandom_range(0, 19) == 0);
            step("rand", e, fv, f, bv, b, m);
        end

        // Saturation of the event counter.
        do_reset();
        load_base(100);
        for (int i = 0; i < 260; i++) begin
            repeat (3) feat("sat_up", 401);
            feat("sat_dn", 10);
            repeat (4) feat("sat_ref", 0);
        end
        check_eq("sat_255", event_count, 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
